// File: rtl/regfile_write_sequencer.sv
// Single write-port owner for register_file: boot-loads x1..x(N-1) after reset,
// then round-robins the port between core writeback and the debug write path.
module regfile_write_sequencer #(
    parameter int          REGISTER_DEPTH = 32,
    parameter logic [31:0] STACKADDR      = 32'hFFFF_FFFF,
    parameter logic [31:0] HARTID         = 32'h0000_0000,
    parameter logic [31:0] DTB_ADDR       = 32'h81FF_F800
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        core_we,
    input  logic [4:0]  core_rd,
    input  logic [31:0] core_wd,
    output logic        core_stall,
    input  logic        dbg_req,
    input  logic [4:0]  dbg_rd,
    input  logic [31:0] dbg_wd,
    output logic        dbg_ack,
    output logic        rf_we,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd,
    output logic        init_done,
    output logic        state
);

    localparam int IW = $clog2(REGISTER_DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(REGISTER_DEPTH - 1);

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
    typedef enum logic {GRANT_CORE = 1'b0, GRANT_DBG = 1'b1} grant_t;

    state_t        state_q;
    grant_t        last_grant;
    logic [IW-1:0] idx;
    logic          init_done_q;

    logic          core_live;
    logic          dbg_live;
    logic          grant_core;
    logic          grant_dbg;
    logic [31:0]   boot_wd;

    // A request to x0 is a null request: it never competes for the port.
    assign core_live = core_we && (core_rd != 5'd0);
    assign dbg_live  = dbg_req && (dbg_rd != 5'd0);

    assign state     = state_q;
    assign init_done = init_done_q;

    // Compared at 32 bits so small depths cannot alias x10/x11 onto low indices.
    always_comb begin
        boot_wd = 32'd0;
        if (32'(idx) == 32'd2) begin
            boot_wd = STACKADDR;
        end else if (32'(idx) == 32'd10) begin
            boot_wd = HARTID;
        end else if (32'(idx) == 32'd11) begin
            boot_wd = DTB_ADDR;
        end
    end

    // Outputs are gated by resetn so they read as reset values while held in reset.
    always_comb begin
        rf_we      = 1'b0;
        rf_a3      = 5'd0;
        rf_wd      = 32'd0;
        core_stall = core_we;
        dbg_ack    = 1'b0;
        grant_core = 1'b0;
        grant_dbg  = 1'b0;
        if (resetn) begin
            if (state_q == INIT) begin
                rf_we = 1'b1;
                rf_a3 = 5'(idx);
                rf_wd = boot_wd;
            end else begin
                grant_core = core_live && (!dbg_live || last_grant == GRANT_DBG);
                grant_dbg  = dbg_live && !grant_core;
                core_stall = core_live && !grant_core;
                dbg_ack    = dbg_req && ((dbg_rd == 5'd0) || grant_dbg);
                if (grant_core) begin
                    rf_we = 1'b1;
                    rf_a3 = core_rd;
                    rf_wd = core_wd;
                end else if (grant_dbg) begin
                    rf_we = 1'b1;
                    rf_a3 = dbg_rd;
                    rf_wd = dbg_wd;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= INIT;
            idx         <= IW'(1);
            last_grant  <= GRANT_DBG;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    if (idx == LAST_IDX) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                RUN: begin
                    if (grant_core) begin
                        last_grant <= GRANT_CORE;
                    end else if (grant_dbg) begin
                        last_grant <= GRANT_DBG;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Scoreboard bench for regfile_write_sequencer: boot load, INIT stall, contention,
// null requests, reset mid-init, and an rv32e (depth 16) instance.
module tb_regfile_write_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        core_we;
    logic [4:0]  core_rd;
    logic [31:0] core_wd;
    logic        core_stall;
    logic        dbg_req;
    logic [4:0]  dbg_rd;
    logic [31:0] dbg_wd;
    logic        dbg_ack;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        init_done;
    logic        state;

    logic        resetn_e;
    logic        core_stall_e;
    logic        dbg_ack_e;
    logic        rf_we_e;
    logic [4:0]  rf_a3_e;
    logic [31:0] rf_wd_e;
    logic        init_done_e;
    logic        state_e;

    int n_cmp = 0;
    int n_bad = 0;
    logic [36:0] exp_q[$];
    logic [36:0] exp_e_q[$];

    always #5 clk = ~clk;

    regfile_write_sequencer dut (
        .clk(clk), .resetn(resetn),
        .core_we(core_we), .core_rd(core_rd), .core_wd(core_wd), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_rd(dbg_rd), .dbg_wd(dbg_wd), .dbg_ack(dbg_ack),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .init_done(init_done), .state(state)
    );

    regfile_write_sequencer #(.REGISTER_DEPTH(16)) dut_e (
        .clk(clk), .resetn(resetn_e),
        .core_we(1'b0), .core_rd(5'd0), .core_wd(32'd0), .core_stall(core_stall_e),
        .dbg_req(1'b0), .dbg_rd(5'd0), .dbg_wd(32'd0), .dbg_ack(dbg_ack_e),
        .rf_we(rf_we_e), .rf_a3(rf_a3_e), .rf_wd(rf_wd_e),
        .init_done(init_done_e), .state(state_e)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] boot_val(input int i);
        case (i)
            2:       return 32'hFFFF_FFFF;
            10:      return 32'h0000_0000;
            11:      return 32'h81FF_F800;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Each pushed expectation belongs to the very next sampled cycle.
    task automatic at_neg();
        logic [36:0] e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("write_we", rf_we, 1'b1);
            check("write_data", {27'd0, rf_a3, rf_wd}, {27'd0, e});
        end else begin
            check("idle_we", rf_we, 1'b0);
            check("idle_bus", {27'd0, rf_a3, rf_wd}, 64'd0);
        end
        if (rf_we) check("we_with_x0", rf_a3 == 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input logic we, input logic [4:0] rd, input logic [31:0] wd);
        core_we = we;
        core_rd = rd;
        core_wd = wd;
    endtask

    task automatic set_dbg(input logic req, input logic [4:0] rd, input logic [31:0] wd);
        dbg_req = req;
        dbg_rd  = rd;
        dbg_wd  = wd;
    endtask

    task automatic boot(input int upto, input logic stalling);
        for (int i = 1; i <= upto; i++) begin
            exp_q.push_back({5'(i), boot_val(i)});
            at_neg();
            check("init_done_low", init_done, 1'b0);
            check("init_stall", core_stall, stalling);
            check("init_ack", dbg_ack, 1'b0);
            tick();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, rf_we, 1'b0);
        check({tag, "_bus"}, {27'd0, rf_a3, rf_wd}, 64'd0);
        check({tag, "_ack"}, dbg_ack, 1'b0);
        check({tag, "_done"}, init_done, 1'b0);
        check({tag, "_stall"}, core_stall, core_we);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        who;

        resetn   = 1'b0;
        resetn_e = 1'b0;
        set_core(1'b1, 5'd9, 32'h1234_5678);
        set_dbg(1'b1, 5'd3, 32'h8765_4321);
        #2;
        check_reset_outputs("reset");
        check("reset_e_we", rf_we_e, 1'b0);
        check("reset_e_done", init_done_e, 1'b0);
        set_core(1'b0, 5'd0, 32'd0);
        set_dbg(1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Boot load with no requests.
        boot(31, 1'b0);
        check("boot_done", init_done, 1'b1);
        check("boot_state_run", state, 1'b1);

        // First conflict after boot: last_grant is DBG, so core goes first.
        set_core(1'b1, 5'd3, 32'h1111_1111);
        set_dbg(1'b1, 5'd4, 32'h2222_2222);
        exp_q.push_back({5'd3, 32'h1111_1111});
        at_neg();
        check("c1_core_stall", core_stall, 1'b0);
        check("c1_dbg_ack_wait", dbg_ack, 1'b0);
        tick();
        set_core(1'b0, 5'd0, 32'd0);
        exp_q.push_back({5'd4, 32'h2222_2222});
        at_neg();
        check("c1_dbg_ack", dbg_ack, 1'b1);
        tick();
        set_dbg(1'b0, 5'd0, 32'd0);

        // Solo core write leaves last_grant = CORE; next conflict favours debug.
        set_core(1'b1, 5'd9, 32'hCCCC_CCCC);
        exp_q.push_back({5'd9, 32'hCCCC_CCCC});
        at_neg();
        check("solo_core_stall", core_stall, 1'b0);
        tick();
        set_core(1'b1, 5'd12, 32'h3333_3333);
        set_dbg(1'b1, 5'd13, 32'h4444_4444);
        exp_q.push_back({5'd13, 32'h4444_4444});
        at_neg();
        check("c2_dbg_ack", dbg_ack, 1'b1);
        check("c2_core_stall", core_stall, 1'b1);
        tick();
        set_dbg(1'b0, 5'd0, 32'd0);
        exp_q.push_back({5'd12, 32'h3333_3333});
        at_neg();
        check("c2_core_go", core_stall, 1'b0);
        tick();

        // Same rd from both: round-robin order, later writer wins.
        set_core(1'b1, 5'd20, 32'h5555_5555);
        set_dbg(1'b1, 5'd20, 32'h6666_6666);
        exp_q.push_back({5'd20, 32'h6666_6666});
        at_neg();
        check("same_rd_dbg_ack", dbg_ack, 1'b1);
        check("same_rd_core_stall", core_stall, 1'b1);
        tick();
        set_dbg(1'b0, 5'd0, 32'd0);
        exp_q.push_back({5'd20, 32'h5555_5555});
        at_neg();
        check("same_rd_core_go", core_stall, 1'b0);
        tick();
        set_core(1'b0, 5'd0, 32'd0);

        // Null requests complete without the port.
        set_core(1'b1, 5'd0, 32'hBAD0_0001);
        set_dbg(1'b1, 5'd0, 32'hBAD0_0002);
        at_neg();
        check("null_both_stall", core_stall, 1'b0);
        check("null_both_ack", dbg_ack, 1'b1);
        tick();
        set_core(1'b1, 5'd7, 32'h7777_7777);
        exp_q.push_back({5'd7, 32'h7777_7777});
        at_neg();
        check("null_dbg_ack", dbg_ack, 1'b1);
        check("core7_stall", core_stall, 1'b0);
        tick();
        set_core(1'b0, 5'd0, 32'd0);
        set_dbg(1'b0, 5'd0, 32'd0);

        // last_grant = CORE; a null debug request must not flip it.
        set_dbg(1'b1, 5'd0, 32'd0);
        at_neg();
        check("null_dbg_alone_ack", dbg_ack, 1'b1);
        tick();
        set_core(1'b1, 5'd14, 32'hABCD_0014);
        set_dbg(1'b1, 5'd15, 32'hABCD_0015);
        exp_q.push_back({5'd15, 32'hABCD_0015});
        at_neg();
        check("lg_after_null_dbg", core_stall, 1'b1);
        tick();
        set_dbg(1'b0, 5'd0, 32'd0);
        exp_q.push_back({5'd14, 32'hABCD_0014});
        at_neg();
        tick();
        set_core(1'b0, 5'd0, 32'd0);

        // Make last_grant = DBG, then a null core request must not flip it.
        set_dbg(1'b1, 5'd21, 32'h2121_2121);
        exp_q.push_back({5'd21, 32'h2121_2121});
        at_neg();
        check("solo_dbg_ack", dbg_ack, 1'b1);
        tick();
        set_dbg(1'b0, 5'd0, 32'd0);
        set_core(1'b1, 5'd0, 32'h0);
        at_neg();
        check("null_core_alone_stall", core_stall, 1'b0);
        tick();
        set_core(1'b1, 5'd22, 32'h2222_0022);
        set_dbg(1'b1, 5'd23, 32'h2323_0023);
        exp_q.push_back({5'd22, 32'h2222_0022});
        at_neg();
        check("lg_after_null_core", dbg_ack, 1'b0);
        tick();
        set_core(1'b0, 5'd0, 32'd0);
        exp_q.push_back({5'd23, 32'h2323_0023});
        at_neg();
        check("lg_after_null_core_ack", dbg_ack, 1'b1);
        tick();
        set_dbg(1'b0, 5'd0, 32'd0);

        // Random uncontested writes: zero added latency.
        for (int k = 0; k < 8; k++) begin
            who = 1'($urandom_range(0, 1));
            rd  = 5'($urandom_range(1, 31));
            wd  = $urandom;
            if (who) set_core(1'b1, rd, wd);
            else     set_dbg(1'b1, rd, wd);
            exp_q.push_back({rd, wd});
            at_neg();
            if (who) check("rand_core_stall", core_stall, 1'b0);
            else     check("rand_dbg_ack", dbg_ack, 1'b1);
            tick();
            set_core(1'b0, 5'd0, 32'd0);
            set_dbg(1'b0, 5'd0, 32'd0);
        end
        check("run_queue_drained", exp_q.size(), 0);

        // Core request held from reset release: stalled through INIT.
        resetn = 1'b0;
        set_core(1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        check_reset_outputs("reset2");
        tick();
        resetn = 1'b1;
        boot(31, 1'b1);
        exp_q.push_back({5'd5, 32'hDEAD_BEEF});
        at_neg();
        check("post_init_core_stall", core_stall, 1'b0);
        check("post_init_done", init_done, 1'b1);
        tick();
        set_core(1'b0, 5'd0, 32'd0);

        // Reset pulse at idx = 17, then a full restart from x1.
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        boot(16, 1'b0);
        check("abort_point_a3", rf_a3, 5'd17);
        resetn = 1'b0;
        set_core(1'b1, 5'd6, 32'h6);
        set_dbg(1'b1, 5'd8, 32'h8);
        #1;
        check_reset_outputs("mid_init_reset");
        set_core(1'b0, 5'd0, 32'd0);
        set_dbg(1'b0, 5'd0, 32'd0);
        tick();
        resetn = 1'b1;
        boot(31, 1'b0);
        check("restart_done", init_done, 1'b1);
        check("restart_queue_drained", exp_q.size(), 0);

        // rv32e instance: 15 boot writes, nothing at x16 or above.
        resetn_e = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            logic [36:0] e;
            exp_e_q.push_back({5'(i), boot_val(i)});
            @(negedge clk);
            e = exp_e_q.pop_front();
            check("e_write_we", rf_we_e, 1'b1);
            check("e_write_data", {27'd0, rf_a3_e, rf_wd_e}, {27'd0, e});
            check("e_init_done_low", init_done_e, 1'b0);
            tick();
        end
        check("e_init_done", init_done_e, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("e_no_extra_write", rf_we_e, 1'b0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
